// File: rtl/census_stream_ctrl.sv
// Flow controller for the 9x7 census core: turns a valid/ready pixel stream into
// the core's en strobe, flushes the core after each frame and tags its outputs.
module census_stream_ctrl #(
   parameter int IMAGE_WIDTH  = 640,
   parameter int IMAGE_HEIGHT = 480,
   parameter int BUSDATAWID   = 9,
   parameter int CORE_LATENCY = 3*IMAGE_WIDTH+6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [7:0]            s_pix,
   input  logic                  s_sof,
   input  logic                  s_eol,
   output logic                  core_en,
   output logic [BUSDATAWID-1:0] core_data,
   output logic                  core_sof,
   output logic                  core_eol,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_sof,
   output logic                  m_eol,
   output logic                  m_border,
   output logic                  frame_done,
   output logic                  err_sync
);
   localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
   localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
   localparam int NW = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT + CORE_LATENCY + 1);
   localparam int FW = $clog2(CORE_LATENCY + 1);

   localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH-1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT-1);
   localparam logic [CW-1:0] COL_LO   = CW'(4);
   localparam logic [CW-1:0] COL_HI   = CW'(IMAGE_WIDTH-5);
   localparam logic [RW-1:0] ROW_LO   = RW'(3);
   localparam logic [RW-1:0] ROW_HI   = RW'(IMAGE_HEIGHT-4);
   localparam logic [NW-1:0] LAT_N    = NW'(CORE_LATENCY);
   localparam logic [FW-1:0] LAT_F    = FW'(CORE_LATENCY);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t        state, nextState;
   logic [CW-1:0] inCol, outCol;
   logic [RW-1:0] inRow, outRow;
   logic [NW-1:0] stepCnt, stepNext;
   logic [FW-1:0] flushCnt;
   logic          hold, accept, sofStep, lastOut;

   assign hold     = m_valid & ~m_ready;
   assign accept   = m_valid & m_ready;
   assign lastOut  = (outCol == LAST_COL) & (outRow == LAST_ROW);
   assign stepNext = stepCnt + NW'(1);
   // Any stepped SOF pixel (IDLE start or mid-frame restart) is step 1 of a new frame.
   assign sofStep  = core_en & s_sof & (state != FLUSH);

   assign core_data  = (state == FLUSH) ? '0 : BUSDATAWID'({s_sof, s_pix});
   assign core_sof   = (state != FLUSH) & s_sof;
   assign core_eol   = (state != FLUSH) & s_eol;
   assign frame_done = accept & lastOut;
   assign m_sof      = m_valid & (outRow == '0) & (outCol == '0);
   assign m_eol      = m_valid & (outCol == LAST_COL);
   assign m_border   = m_valid & ((outRow < ROW_LO) | (outRow > ROW_HI) |
                                  (outCol < COL_LO) | (outCol > COL_HI));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      s_ready   = 1'b0;
      core_en   = 1'b0;
      err_sync  = 1'b0;
      case (state)
         IDLE: begin
            s_ready = 1'b1;
            core_en = s_valid & s_sof;
            if (s_valid & s_sof) nextState = RUN;
         end
         RUN: begin
            s_ready = ~hold;
            core_en = s_valid & ~hold;
            if (s_valid & ~hold) begin
               if (s_sof) err_sync = 1'b1;
               else begin
                  err_sync = s_eol ^ (inCol == LAST_COL);
                  if ((inCol == LAST_COL) && (inRow == LAST_ROW)) nextState = FLUSH;
               end
            end
         end
         FLUSH: begin
            core_en = ~hold & (flushCnt != LAT_F);
            if (frame_done) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inCol    <= '0;
         inRow    <= '0;
         outCol   <= '0;
         outRow   <= '0;
         stepCnt  <= '0;
         flushCnt <= '0;
         m_valid  <= 1'b0;
      end else begin
         // Framing errors are flagged but counting stays positional.
         if (sofStep) begin
            inCol <= CW'(1);
            inRow <= '0;
         end else if (core_en && state == RUN) begin
            if (inCol == LAST_COL) begin
               inCol <= '0;
               inRow <= (inRow == LAST_ROW) ? '0 : inRow + RW'(1);
            end else begin
               inCol <= inCol + CW'(1);
            end
         end

         flushCnt <= (state != FLUSH) ? '0 : flushCnt + FW'(core_en);

         if (sofStep)         stepCnt <= NW'(1);
         else if (frame_done) stepCnt <= '0;
         else if (core_en)    stepCnt <= stepNext;

         if (sofStep)                          m_valid <= 1'b0;
         else if (core_en && stepNext > LAT_N) m_valid <= 1'b1;
         else if (m_ready)                     m_valid <= 1'b0;

         if (sofStep || frame_done) begin
            outCol <= '0;
            outRow <= '0;
         end else if (accept) begin
            if (outCol == LAST_COL) begin
               outCol <= '0;
               outRow <= (outRow == LAST_ROW) ? '0 : outRow + RW'(1);
            end else begin
               outCol <= outCol + CW'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_census_stream_ctrl.sv
// Directed bench for census_stream_ctrl on a 16x8 frame (core latency 54).
module tb_census_stream_ctrl;
   localparam int W = 16, H = 8, L = 3*W+6, N = W*H;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       s_valid = 1'b0, s_sof = 1'b0, s_eol = 1'b0, m_ready = 1'b1;
   logic [7:0] s_pix = '0;
   logic [8:0] core_data;
   logic       s_ready, core_en, core_sof, core_eol, m_valid, m_sof, m_eol, m_border;
   logic       frame_done, err_sync;

   int passCnt = 0, totalCnt = 0;
   int rSteps, rFirst, rOut, rOutErr, rFlush, rFlushBad, rStallErr, rDone, rErr, rDataErr, rTimeout;
   int strayEn, strayRdyBad, strayVld;
   logic bSeen [N];

   always #5 clk = ~clk;

   census_stream_ctrl #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .BUSDATAWID(9), .CORE_LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_pix(s_pix),
      .s_sof(s_sof), .s_eol(s_eol), .core_en(core_en), .core_data(core_data),
      .core_sof(core_sof), .core_eol(core_eol), .m_valid(m_valid), .m_ready(m_ready),
      .m_sof(m_sof), .m_eol(m_eol), .m_border(m_border), .frame_done(frame_done),
      .err_sync(err_sync));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCnt++;
      assert (obs === exp) passCnt++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic bModel(input int i);
      int r, c;
      r = i / W;
      c = i % W;
      return (r < 3) || (r > H-4) || (c < 4) || (c > W-5);
   endfunction

   // Streams one frame and scores every cycle; abortAt restarts with SOF at that
   // pixel index, rstAtFlush leaves the loop after that many flush steps.
   task automatic runFrame(input bit stall, input int abortAt, input int rstAtFlush);
      int  px, oi, cyc;
      bit  aborted, seen;
      px = 0; oi = 0; cyc = 0; aborted = 0; seen = 0;
      rSteps = 0; rFirst = -1; rOutErr = 0; rFlush = 0; rFlushBad = 0;
      rStallErr = 0; rDone = 0; rErr = 0; rDataErr = 0; rTimeout = 0;
      while (oi < N) begin
         if (cyc == 3000) begin rTimeout = 1; break; end
         if (rstAtFlush > 0 && rFlush >= rstAtFlush) break;
         cyc++;
         @(negedge clk);
         if (!aborted && abortAt > 0 && px == abortAt) begin
            px = 0; aborted = 1; rSteps = 0;
         end
         m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         s_valid = (px < N);
         s_pix   = 8'(px);
         s_sof   = (px == 0);
         s_eol   = (px < N) && (px % W == W-1);
         #1;
         if (m_valid && !seen) begin seen = 1; rFirst = rSteps; end
         if (core_en === 1'b1) begin
            rSteps++;
            if (!s_valid) begin
               rFlush++;
               if (core_data !== 9'd0) rFlushBad++;
            end else if (core_data !== {s_sof, s_pix}) rDataErr++;
         end
         if (m_valid && !m_ready && (core_en !== 1'b0 || s_ready !== 1'b0)) rStallErr++;
         if (err_sync === 1'b1) rErr++;
         if (frame_done === 1'b1) rDone++;
         if (m_valid === 1'b1 && m_ready) begin
            if (m_sof !== (oi == 0) || m_eol !== (oi % W == W-1) ||
                m_border !== bModel(oi) || frame_done !== (oi == N-1)) rOutErr++;
            bSeen[oi] = m_border;
            oi++;
         end else if (frame_done !== 1'b0) rOutErr++;
         if (s_valid && s_ready) px++;
      end
      rOut = oi;
      @(negedge clk);
      s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; m_ready = 1'b1;
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_core_en", core_en, 0);
      chk("rst_m_flags", {m_sof, m_eol, m_border}, 0);
      chk("rst_pulses", {frame_done, err_sync}, 0);
      @(negedge clk); rst_n = 1'b1;

      // Free-running frame
      runFrame(0, 0, 0);
      chk("f1_timeout", rTimeout, 0);
      chk("f1_outputs", rOut, N);
      chk("f1_first_valid_step", rFirst, L+1);
      chk("f1_flush_steps", rFlush, L);
      chk("f1_flush_data", rFlushBad, 0);
      chk("f1_core_data", rDataErr, 0);
      chk("f1_out_flags", rOutErr, 0);
      chk("f1_frame_done", rDone, 1);
      chk("f1_err_sync", rErr, 0);
      chk("border_2_4", bSeen[2*W+4], 1);
      chk("border_3_3", bSeen[3*W+3], 1);
      chk("border_3_4", bSeen[3*W+4], 0);
      chk("border_4_11", bSeen[4*W+11], 0);
      chk("border_4_12", bSeen[4*W+12], 1);
      #1;
      chk("f1_idle_ready", s_ready, 1);

      // Consumer backpressure
      runFrame(1, 0, 0);
      chk("f2_timeout", rTimeout, 0);
      chk("f2_outputs", rOut, N);
      chk("f2_out_flags", rOutErr, 0);
      chk("f2_stall_hold", rStallErr, 0);
      chk("f2_flush_steps", rFlush, L);
      chk("f2_frame_done", rDone, 1);

      // Stray pixels without SOF while idle
      strayEn = 0; strayRdyBad = 0; strayVld = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         s_valid = 1'b1; s_sof = 1'b0; s_pix = 8'(i + 7);
         #1;
         if (core_en !== 1'b0) strayEn++;
         if (s_ready !== 1'b1) strayRdyBad++;
         if (m_valid !== 1'b0) strayVld++;
      end
      chk("stray_core_en", strayEn, 0);
      chk("stray_ready", strayRdyBad, 0);
      chk("stray_no_output", strayVld, 0);
      runFrame(0, 0, 0);
      chk("f3_outputs", rOut, N);
      chk("f3_first_valid_step", rFirst, L+1);
      chk("f3_out_flags", rOutErr, 0);

      // SOF mid-frame at row 2, col 5
      runFrame(0, 2*W+5, 0);
      chk("f4_err_sync", rErr, 1);
      chk("f4_outputs", rOut, N);
      chk("f4_first_valid_step", rFirst, L+1);
      chk("f4_out_flags", rOutErr, 0);
      chk("f4_flush_steps", rFlush, L);

      // Reset in the middle of FLUSH
      runFrame(0, 0, 20);
      chk("f5_valid_before_rst", m_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("f5_rst_m_valid", m_valid, 0);
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("f5_post_m_valid", m_valid, 0);
      chk("f5_post_s_ready", s_ready, 1);
      chk("f5_post_core_en", core_en, 0);
      runFrame(0, 0, 0);
      chk("f6_outputs", rOut, N);
      chk("f6_first_valid_step", rFirst, L+1);
      chk("f6_out_flags", rOutErr, 0);
      chk("f6_frame_done", rDone, 1);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end
endmodule
